// File: rtl/tmr_recovery_pkg.sv
// Purpose : shared state encoding, default parameters and counter sizing for
//           the TMR recovery controller.
// Latency : n/a (declarations only).   Backpressure: n/a.
package tmr_recovery_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RESET   = 3'd2,
    RESTART = 3'd3,
    FATAL   = 3'd4
  } state_e;

  // Plain-vector aliases of the enum, used by the FSM registers.
  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_HOLD    = HOLD;
  localparam logic [2:0] ST_RESET   = RESET;
  localparam logic [2:0] ST_RESTART = RESTART;
  localparam logic [2:0] ST_FATAL   = FATAL;

  localparam int DEF_HOLD_TIMEOUT = 256;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_GOOD_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES  = 3;
  localparam int DEF_ERR_CNT_W    = 8;

  // Width able to hold 0 .. max(a,b,c)-1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/tmr_cycle_timer.sv
// Purpose : loadable up-counter with clear and terminal-count flag.
// Latency : clear/load/increment take effect on the next clk edge; tc_o is combinational on the count.
// Backpressure: none; en_i simply freezes the count.
// Ports   : clk, rst_n (sync, active low), clr_i (to zero, highest priority),
//           load_i/load_val_i, en_i (count up), term_i (terminal value), tc_o (count == term_i).
module tmr_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Purpose : sequences core recovery after a TMR error: gate fetch, wait for idle
//           (bounded), pulse core reset, restart; escalates to latched FATAL.
// Latency : all outputs registered, decoded from next state (1 cycle after the causing input).
// Backpressure: core_busy_i stalls HOLD up to HOLD_TIMEOUT cycles; fetch_enable_i passes through in IDLE only.
// Ports   : clk, rst_n | tmr_err_i, fetch_enable_i, core_busy_i, clear_i |
//           fetch_enable_o, core_rst_no, recovering_o, done_irq_o, timeout_o, fatal_o, err_count_o.
module tmr_recovery_ctrl
  import tmr_recovery_pkg::*;
#(
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int GOOD_CYCLES  = DEF_GOOD_CYCLES,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int ERR_CNT_W    = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tmr_err_i,
  input  logic                 fetch_enable_i,
  input  logic                 core_busy_i,
  input  logic                 clear_i,
  output logic                 fetch_enable_o,
  output logic                 core_rst_no,
  output logic                 recovering_o,
  output logic                 done_irq_o,
  output logic                 timeout_o,
  output logic                 fatal_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int CNT_W   = cnt_width(HOLD_TIMEOUT, RST_CYCLES, GOOD_CYCLES);
  localparam int RETRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]     HOLD_TERM = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     RST_TERM  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     GOOD_TERM = CNT_W'(GOOD_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

  logic [2:0]           state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 fetch_q, rst_no_q, recov_q, done_q, fatal_q;

  logic                 tmr_tc, gw_tc, gw_clr;
  logic [CNT_W-1:0]     tmr_term;

  // One timer serves both HOLD and RESET; it restarts from 0 on every state
  // change so each phase measures its own dwell time.
  assign tmr_term = (state_q == ST_HOLD) ? HOLD_TERM : RST_TERM;

  tmr_cycle_timer #(.W(CNT_W)) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_d != state_q),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (1'b1),
    .term_i     (tmr_term),
    .tc_o       (tmr_tc)
  );

  // Good window only accumulates consecutive error-free IDLE cycles; it starts
  // over on any error, on leaving IDLE, and after each completed window.
  assign gw_clr = (state_q != ST_IDLE) | tmr_err_i | gw_tc;

  tmr_cycle_timer #(.W(CNT_W)) u_good_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (gw_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (1'b1),
    .term_i     (GOOD_TERM),
    .tc_o       (gw_tc)
  );

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    timeout_d = timeout_q;
    err_cnt_d = err_cnt_q;

    // Clear first, then count, so a coincident error leaves the count at 1.
    if (clear_i) begin
      err_cnt_d = '0;
      timeout_d = 1'b0;
    end
    if (tmr_err_i && (err_cnt_d != ERR_MAX)) err_cnt_d = err_cnt_d + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tmr_err_i) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FATAL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_HOLD;
          end
        end else if (gw_tc) begin
          retry_d = '0;
        end
      end
      ST_HOLD: begin
        if (!core_busy_i) begin
          state_d = ST_RESET;
        end else if (tmr_tc) begin
          timeout_d = 1'b1;
          state_d   = ST_RESET;
        end
      end
      ST_RESET: begin
        if (tmr_tc) state_d = ST_RESTART;
      end
      ST_RESTART: begin
        state_d = ST_IDLE;
      end
      ST_FATAL: begin
        if (clear_i) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        retry_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      err_cnt_q <= '0;
      timeout_q <= 1'b0;
      fetch_q   <= 1'b0;
      rst_no_q  <= 1'b1;
      recov_q   <= 1'b0;
      done_q    <= 1'b0;
      fatal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      err_cnt_q <= err_cnt_d;
      timeout_q <= timeout_d;
      fetch_q   <= (state_d == ST_IDLE) & fetch_enable_i;
      rst_no_q  <= !((state_d == ST_RESET) || (state_d == ST_FATAL));
      recov_q   <= (state_d == ST_HOLD) || (state_d == ST_RESET) || (state_d == ST_RESTART);
      done_q    <= (state_d == ST_RESTART);
      fatal_q   <= (state_d == ST_FATAL);
    end
  end

  assign fetch_enable_o = fetch_q;
  assign core_rst_no    = rst_no_q;
  assign recovering_o   = recov_q;
  assign done_irq_o     = done_q;
  assign timeout_o      = timeout_q;
  assign fatal_o        = fatal_q;
  assign err_count_o    = err_cnt_q;

endmodule
